// File: rtl/fb_scanout_if.sv
// Pixel write stream (x, y, colour, plot) from the screen-draw blocks into the framebuffer.
interface fb_scanout_if;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  modport master (output plot, x, y, colour);
  modport slave  (input  plot, x, y, colour);
endinterface

// File: rtl/fb_scanout.sv
// 160x120x3 framebuffer with an independent write port and a free-running raster scan-out
// producing blanking, active-low syncs and a frame-start marker, all one clock behind the counters.
module fb_scanout #(
  parameter logic [7:0] H_ACTIVE = 8'd160,
  parameter logic [7:0] H_FRONT  = 8'd4,
  parameter logic [7:0] H_SYNC   = 8'd24,
  parameter logic [7:0] H_BACK   = 8'd12,
  parameter logic [7:0] V_ACTIVE = 8'd120,
  parameter logic [7:0] V_FRONT  = 8'd2,
  parameter logic [7:0] V_SYNC   = 8'd2,
  parameter logic [7:0] V_BACK   = 8'd6
) (
  input  logic         clk,
  input  logic         rst,
  fb_scanout_if.slave  pix,
  output logic [2:0]   pix_colour,
  output logic         hsync_n,
  output logic         vsync_n,
  output logic         blank,
  output logic         frame_start,
  output logic [7:0]   drop_count
);

  localparam logic [7:0] H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [7:0] V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [7:0] HS_START = H_ACTIVE + H_FRONT;
  localparam logic [7:0] HS_STOP  = HS_START + H_SYNC;
  localparam logic [7:0] VS_START = V_ACTIVE + V_FRONT;
  localparam logic [7:0] VS_STOP  = VS_START + V_SYNC;
  localparam int         FB_DEPTH = int'(H_ACTIVE) * int'(V_ACTIVE);

  function automatic logic [14:0] fb_addr(input logic [7:0] col, input logic [6:0] row);
    return 15'(row) * 15'(H_ACTIVE) + 15'(col);
  endfunction

  logic [7:0]  h_cnt_r, v_cnt_r;
  logic [7:0]  h_nxt_s, v_nxt_s;
  logic        h_last_s, v_last_s;
  logic        in_range_s, wr_en_s, drop_s, visible_s, hs_act_s, vs_act_s;
  logic [14:0] waddr_s, raddr_s;
  logic [2:0]  fb_mem_r [0:FB_DEPTH-1];
  logic [2:0]  ram_q_r;
  logic        blank_r, hsync_n_r, vsync_n_r, frame_start_r;
  logic [7:0]  drop_count_r;

  // Raster stepping, write qualification and per-position decode of the current counters.
  always_comb begin
    h_last_s   = (h_cnt_r == H_TOTAL - 8'd1);
    v_last_s   = (v_cnt_r == V_TOTAL - 8'd1);
    h_nxt_s    = h_last_s ? 8'd0 : h_cnt_r + 8'd1;
    v_nxt_s    = h_last_s ? (v_last_s ? 8'd0 : v_cnt_r + 8'd1) : v_cnt_r;
    in_range_s = (pix.x < H_ACTIVE) && ({1'b0, pix.y} < V_ACTIVE);
    wr_en_s    = pix.plot && in_range_s;
    drop_s     = pix.plot && !in_range_s;
    waddr_s    = fb_addr(pix.x, pix.y);
    visible_s  = (h_cnt_r < H_ACTIVE) && (v_cnt_r < V_ACTIVE);
    raddr_s    = fb_addr(h_cnt_r, v_cnt_r[6:0]);
    hs_act_s   = (h_cnt_r >= HS_START) && (h_cnt_r < HS_STOP);
    vs_act_s   = (v_cnt_r >= VS_START) && (v_cnt_r < VS_STOP);
  end

  // Framebuffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      fb_mem_r[waddr_s] <= pix.colour;
    end
  end

  // Read port: a same-cycle write to this address is not visible until next frame.
  always_ff @(posedge clk) begin
    if (visible_s) begin
      ram_q_r <= fb_mem_r[raddr_s];
    end
  end

  // Raster counters, registered timing outputs and the saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_r       <= 8'd0;
      v_cnt_r       <= 8'd0;
      blank_r       <= 1'b1;
      hsync_n_r     <= 1'b1;
      vsync_n_r     <= 1'b1;
      frame_start_r <= 1'b0;
      drop_count_r  <= 8'd0;
    end else begin
      h_cnt_r       <= h_nxt_s;
      v_cnt_r       <= v_nxt_s;
      blank_r       <= !visible_s;
      hsync_n_r     <= !hs_act_s;
      vsync_n_r     <= !vs_act_s;
      frame_start_r <= (h_cnt_r == 8'd0) && (v_cnt_r == 8'd0);
      drop_count_r  <= (drop_s && (drop_count_r != 8'hFF)) ? drop_count_r + 8'd1 : drop_count_r;
    end
  end

  assign pix_colour  = blank_r ? 3'd0 : ram_q_r;
  assign hsync_n     = hsync_n_r;
  assign vsync_n     = vsync_n_r;
  assign blank       = blank_r;
  assign frame_start = frame_start_r;
  assign drop_count  = drop_count_r;

endmodule
